// File: rtl/ppm_pkg.sv
// Shared types and the channel-value conditioning helper for the PPM frame scheduler.
// Build option: PPM_CLAMP_EN enables min/max clamping of channel values.
package ppm_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, PULSE, GAP, SYNC} ppm_state_e;

    // Working width of the helper arithmetic; callers widen into it and truncate back.
    localparam int SUM_W = 64;

    function automatic logic [SUM_W-1:0] ppm_eff(input logic [SUM_W-1:0] v,
                                                  input logic [SUM_W-1:0] pulse_cyc,
                                                  input logic [SUM_W-1:0] ch_min,
                                                  input logic [SUM_W-1:0] ch_max);
        logic [SUM_W-1:0] r;
        logic             unused_lim;
        r = v;
`ifdef PPM_CLAMP_EN
        unused_lim = 1'b0;
        if (r < ch_min) r = ch_min;
        if (r > ch_max) r = ch_max;
`else
        unused_lim = ^{ch_min, ch_max};
`endif
        // The gap after each marker must be at least one cycle long.
        if (r <= pulse_cyc) r = pulse_cyc + 1;
        return r;
    endfunction

endpackage

// File: rtl/ppm_cycle_cnt.sv
// Loadable down-counter; done is high while the count sits at 1 (last cycle of a state).
module ppm_cycle_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/ppm_frame_sched.sv
// PPM frame scheduler: shadows channel periods at LOAD and plays marker/gap/sync on ppm_out.
// Build option: PPM_CLAMP_EN (see ppm_pkg::ppm_eff).
module ppm_frame_sched
    import ppm_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int CNT_W     = 32,
    parameter int PULSE_CYC = 40000,
    parameter int FRAME_CYC = 2000000,
    parameter int CH_MIN    = 100000,
    parameter int CH_MAX    = 200000,
    parameter int SYNC_MIN  = 300000
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          enable,
    input  logic [NUM_CH*CNT_W-1:0]       ch_val,
    output logic                          ppm_out,
    output logic                          frame_start,
    output logic                          busy,
    output logic [$clog2(NUM_CH+1)-1:0]   cur_ch,
    output logic [31:0]                   frame_cnt
);

    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int ACC_W = CNT_W + $clog2(NUM_CH);
    localparam int TOT_W = ACC_W + 1;

    ppm_state_e       state, nxt;
    logic [CNT_W-1:0] shadow [NUM_CH];
    logic [CNT_W-1:0] eff    [NUM_CH];
    logic [CNT_W-1:0] sync_len, sync_calc, gap_len, cnt_val;
    logic [ACC_W-1:0] sum;
    logic [TOT_W-1:0] used, room;
    logic             cnt_load, cnt_done;

    // Conditioned channel values and the sync gap that fills out the frame.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            eff[i] = CNT_W'(ppm_eff(SUM_W'(ch_val[i*CNT_W +: CNT_W]), SUM_W'(PULSE_CYC),
                                    SUM_W'(CH_MIN), SUM_W'(CH_MAX)));
            sum    = sum + ACC_W'(eff[i]);
        end
        used      = {1'b0, sum} + TOT_W'(PULSE_CYC);
        room      = '0;
        sync_calc = CNT_W'(SYNC_MIN);
        if (used < TOT_W'(FRAME_CYC)) begin
            room = TOT_W'(FRAME_CYC) - used;
            if (room > TOT_W'(SYNC_MIN))
                sync_calc = CNT_W'(room);
        end
    end

    always_comb begin
        gap_len = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (cur_ch == CH_W'(i))
                gap_len = shadow[i] - CNT_W'(PULSE_CYC);
    end

    // Next state and the counter reload for the state being entered.
    always_comb begin
        nxt      = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: if (enable) begin
                nxt = LOAD; cnt_load = 1'b1; cnt_val = CNT_W'(1);
            end
            LOAD: if (cnt_done) begin
                nxt = PULSE; cnt_load = 1'b1; cnt_val = CNT_W'(PULSE_CYC);
            end
            PULSE: if (cnt_done) begin
                cnt_load = 1'b1;
                if (cur_ch < CH_W'(NUM_CH)) begin
                    nxt = GAP;  cnt_val = gap_len;
                end else begin
                    nxt = SYNC; cnt_val = sync_len - CNT_W'(1);
                end
            end
            GAP: if (cnt_done) begin
                nxt = PULSE; cnt_load = 1'b1; cnt_val = CNT_W'(PULSE_CYC);
            end
            SYNC: if (cnt_done) begin
                if (enable) begin
                    nxt = LOAD; cnt_load = 1'b1; cnt_val = CNT_W'(1);
                end else begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    ppm_cycle_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (ACLK),
        .rst      (ARESET),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            ppm_out     <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            cur_ch      <= '0;
            frame_cnt   <= '0;
            sync_len    <= '0;
            for (int i = 0; i < NUM_CH; i++)
                shadow[i] <= '0;
        end else begin
            state       <= nxt;
            ppm_out     <= (nxt != PULSE);
            frame_start <= (nxt == LOAD);
            busy        <= (nxt != IDLE);
            if (state == LOAD) begin
                for (int i = 0; i < NUM_CH; i++)
                    shadow[i] <= eff[i];
                sync_len <= sync_calc;
                cur_ch   <= '0;
            end
            if (state == GAP && cnt_done)
                cur_ch <= cur_ch + CH_W'(1);
            if (state == SYNC && cnt_done)
                frame_cnt <= frame_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ppm_frame_sched.sv
// Directed bench for ppm_frame_sched: waveform segments, frame period, sync floor, shadowing, reset.
module tb_ppm_frame_sched;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int VW     = NUM_CH * CNT_W;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          enable, enable3;
    logic [VW-1:0] ch_val, ch_val3;
    logic          ppm_out, frame_start, busy;
    logic          ppm_out3, frame_start3, busy3;
    logic [2:0]    cur_ch, cur_ch3;
    logic [31:0]   frame_cnt, frame_cnt3;

    int compared   = 0;
    int mismatched = 0;
    int frames_seen = 0;
    int seg [16];
    int nseg;
    int per;

    always #5 ACLK = ~ACLK;

    ppm_frame_sched #(.NUM_CH(4), .CNT_W(32), .PULSE_CYC(4), .FRAME_CYC(100),
                      .CH_MIN(10), .CH_MAX(20), .SYNC_MIN(12)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .ch_val(ch_val),
        .ppm_out(ppm_out), .frame_start(frame_start), .busy(busy),
        .cur_ch(cur_ch), .frame_cnt(frame_cnt));

    ppm_frame_sched #(.NUM_CH(4), .CNT_W(32), .PULSE_CYC(4), .FRAME_CYC(100),
                      .CH_MIN(10), .CH_MAX(20), .SYNC_MIN(20)) u_dut3 (
        .ACLK(ACLK), .ARESET(ARESET), .enable(enable3), .ch_val(ch_val3),
        .ppm_out(ppm_out3), .frame_start(frame_start3), .busy(busy3),
        .cur_ch(cur_ch3), .frame_cnt(frame_cnt3));

    // Frames started on the main instance; frame_start is sampled before the edge updates it.
    always @(posedge ACLK)
        if (frame_start) frames_seen <= frames_seen + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic fs_of(input int which);
        return (which == 0) ? frame_start : frame_start3;
    endfunction

    task automatic wait_fs(input int which, input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge ACLK);
            if (fs_of(which)) return;
        end
        check(tag, 32'd0, 32'd1);
    endtask

    task automatic measure_period(input int which, output int cycles);
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge ACLK);
            cycles++;
            if (fs_of(which)) return;
        end
    endtask

    // Run-length encode ppm_out from the next cycle on; optionally rewrite ch_val and drop
    // enable on sample number poke_at.
    task automatic record(input int which, input int nsegs, input int poke_at,
                          input logic [VW-1:0] poke_ch);
        int   len, cyc;
        logic cur, s;
        nseg = 0;
        @(negedge ACLK);
        cyc = 1;
        cur = (which == 0) ? ppm_out : ppm_out3;
        len = 1;
        while (nseg < nsegs && cyc < 1000) begin
            @(negedge ACLK);
            cyc++;
            if (cyc == poke_at) begin
                ch_val = poke_ch;
                enable = 1'b0;
            end
            s = (which == 0) ? ppm_out : ppm_out3;
            if (s == cur) len++;
            else begin
                seg[nseg] = len;
                nseg++;
                cur = s;
                len = 1;
            end
        end
        if (nseg < nsegs) check("record_timeout", 32'(nseg), 32'(nsegs));
    endtask

    task automatic check_segs(input string tag, input int n, input int exp [16]);
        for (int i = 0; i < n; i++)
            check($sformatf("%s_seg%0d", tag, i), 32'(seg[i]), 32'(exp[i]));
    endtask

    initial begin
        int e2 [16] = '{4,6,4,11,4,16,4,8,4,39,0,0,0,0,0,0};
        int e3 [16] = '{4,16,4,16,4,16,4,16,4,20,0,0,0,0,0,0};
`ifdef PPM_CLAMP_EN
        int e4 [16] = '{4,6,4,16,4,6,4,16,4,36,0,0,0,0,0,0};
`else
        int e4 [16] = '{4,1,4,46,4,6,4,16,4,12,0,0,0,0,0,0};
`endif
        logic [VW-1:0] ch2  = {32'd12, 32'd20, 32'd15, 32'd10};
        logic [VW-1:0] ch4  = {32'd20, 32'd10, 32'd50, 32'd0};
        logic [VW-1:0] ch11 = {32'd11, 32'd11, 32'd11, 32'd11};

        // 1: reset and idle hold
        ARESET = 1'b1; enable = 1'b0; enable3 = 1'b0; ch_val = '0; ch_val3 = '0;
        repeat (3) @(negedge ACLK);
        check("rst_ppm_out", 32'(ppm_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", frame_cnt, 32'd0);
        check("rst_cur_ch", 32'(cur_ch), 32'd0);
        ARESET = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            check("idle_status", 32'({ppm_out, busy, frame_start, cur_ch}), 32'b100000);
        end
        check("idle_frame_cnt", frame_cnt, 32'd0);

        // 2: nominal frame
        ch_val = ch2; enable = 1'b1;
        wait_fs(0, "t2_start_timeout");
        check("t2_cnt_first_load", frame_cnt, 32'd0);
        measure_period(0, per);
        check("t2_period", 32'(per), 32'd100);
        check("t2_frame_cnt", frame_cnt, 32'd1);
        record(0, 10, 0, '0);
        check_segs("t2", 10, e2);

        // 4: floor / clamp of out-of-range channel values
        ch_val = ch4;
        wait_fs(0, "t4_start_timeout");
        record(0, 10, 0, '0);
        check_segs("t4", 10, e4);

        // 5: mid-frame rewrite and enable drop
        ch_val = ch2;
        wait_fs(0, "t5_start_timeout");
        record(0, 9, 18, ch11);
        check_segs("t5", 9, e2);
        check("t5_sync_cur_ch", 32'(cur_ch), 32'd4);
        check("t5_sync_busy", 32'(busy), 32'd1);
        repeat (37) @(negedge ACLK);
        check("t5_last_sync_busy", 32'(busy), 32'd1);
        @(negedge ACLK);
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_frame_cnt", frame_cnt, 32'd6);
        repeat (20) @(negedge ACLK);
        check("t5_idle_ppm", 32'(ppm_out), 32'd1);
        check("t5_frame_cnt_hold", frame_cnt, 32'd6);
        check("t5_no_new_frame", 32'(frames_seen), 32'd6);

        // 3: sync gap floored to SYNC_MIN=20
        ch_val3 = {32'd20, 32'd20, 32'd20, 32'd20}; enable3 = 1'b1;
        wait_fs(1, "t3_start_timeout");
        measure_period(1, per);
        check("t3_period", 32'(per), 32'd104);
        record(1, 10, 0, '0);
        check_segs("t3", 10, e3);
        enable3 = 1'b0;

        // 6: asynchronous reset in the middle of a marker
        ch_val = ch2; enable = 1'b1;
        wait_fs(0, "t6_start_timeout");
        repeat (2) @(negedge ACLK);
        check("t6_in_pulse", 32'(ppm_out), 32'd0);
        ARESET = 1'b1;
        #1;
        check("t6_async_ppm_out", 32'(ppm_out), 32'd1);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_frame_cnt", frame_cnt, 32'd0);
        check("t6_async_cur_ch", 32'(cur_ch), 32'd0);
        enable = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        repeat (5) @(negedge ACLK);
        check("t6_post_status", 32'({ppm_out, busy, frame_start, cur_ch}), 32'b100000);
        check("t6_post_frame_cnt", frame_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
